rpsc_card13_annunciator: RTL

Operator annunciator stage fed by the eight latched-alarm (LA) outputs of the FF41–FF48 trip card. Each channel runs an ISA-18.1-style lamp sequence: alert flash, acknowledged steady, cleared slow flash, then normal. The block drives a common horn and captures the first-out channel. It sits directly downstream of the trip card on the same clock and feeds the panel lamp drivers.

---
 rtl/rpsc_pkg.sv | 25 ++
 rtl/rpsc_ann_channel.sv | 47 ++++
 rtl/rpsc_card13_annunciator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rpsc_pkg.sv
// Shared types and constants for the card-13 operator annunciator.
package rpsc_pkg;

  // Per-channel lamp sequence state.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ALERT   = 2'd1,
    ACKED   = 2'd2,
    CLEARED = 2'd3
  } ann_state_e;

  // Slow flash half-period expressed in fast flash half-periods.
  localparam int ANN_SLOW_RATIO = 4;

  // Lamp drive for a given sequence state and the two flasher phases.
  function automatic logic ann_lamp(ann_state_e s, logic fast, logic slow);
    case (s)
      ALERT:   return fast;
      ACKED:   return 1'b1;
      CLEARED: return slow;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rpsc_ann_channel.sv
// One annunciator channel: ISA-18.1-style lock-in lamp sequence.
module rpsc_ann_channel
  import rpsc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       la,
  input  logic       ack_press,
  input  logic       rst_press,
  input  logic       fast,
  input  logic       slow,
  output ann_state_e state,
  output logic       lamp,
  output logic       entering_alert
);

  ann_state_e state_q, state_d;

  // Next-state rules; each channel reacts only to the event relevant to its state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      NORMAL:  if (la) state_d = ALERT;
      ALERT:   if (ack_press) state_d = la ? ACKED : CLEARED;
      ACKED:   if (!la) state_d = CLEARED;
      CLEARED: begin
        // A returning alarm outranks a lamp-reset press in the same cycle.
        if (la)             state_d = ALERT;
        else if (rst_press) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is updated with <= so every flop samples pre-edge values.
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  assign state          = state_q;
  assign lamp           = ann_lamp(state_q, fast, slow);
  assign entering_alert = (state_d == ALERT) && (state_q != ALERT);

endmodule

// File: rtl/rpsc_card13_annunciator.sv
// Card-13 annunciator: eight lamp sequences, common horn, first-out capture.
module rpsc_card13_annunciator
  import rpsc_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         la_in,
  input  logic                    ack_pb,
  input  logic                    rst_pb,
  output logic [N_CH-1:0]         lamp,
  output logic                    horn,
  output logic [$clog2(N_CH)-1:0] first_out_idx,
  output logic                    first_out_vld
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(FLASH_DIV);
  localparam int DIV_W = $clog2(ANN_SLOW_RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANN_SLOW_RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             fast_q, fast_d, slow_q, slow_d;
  logic             ack_q, rst_q;
  logic             ack_press, rst_press;
  logic [IDX_W-1:0] fo_idx_q, fo_idx_d;
  logic             fo_vld_q, fo_vld_d;
  logic [N_CH-1:0]  entering;
  ann_state_e       ch_state [N_CH];

  // Flasher: fast toggles on each counter wrap, slow on every ANN_SLOW_RATIO-th fast toggle.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    div_d  = div_q;
    fast_d = fast_q;
    slow_d = slow_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      fast_d = ~fast_q;
      div_d  = div_q + 1'b1;
      if (div_q == DIV_LAST) slow_d = ~slow_q;
    end
  end

  // Pushbutton rising-edge detection; history presets high so a held button is not a press.
  assign ack_press = ack_pb & ~ack_q;
  assign rst_press = rst_pb & ~rst_q;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      rpsc_ann_channel u_ch (
        .clk            (clk),
        .reset          (reset),
        .la             (la_in[g]),
        .ack_press      (ack_press),
        .rst_press      (rst_press),
        .fast           (fast_q),
        .slow           (slow_q),
        .state          (ch_state[g]),
        .lamp           (lamp[g]),
        .entering_alert (entering[g])
      );
    end
  endgenerate

  // Horn and first-out: capture the lowest entering channel, release once every channel is NORMAL.
  always_comb begin
    logic all_normal;
    logic any_enter;
    logic [IDX_W-1:0] low_idx;
    horn       = 1'b0;
    all_normal = 1'b1;
    any_enter  = 1'b0;
    low_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_state[i] == ALERT)  horn = 1'b1;
      if (ch_state[i] != NORMAL) all_normal = 1'b0;
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (entering[i]) begin
        any_enter = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
    fo_vld_d = fo_vld_q;
    fo_idx_d = fo_idx_q;
    if (all_normal) fo_vld_d = 1'b0;
    if ((!fo_vld_q || all_normal) && any_enter) begin
      fo_vld_d = 1'b1;
      fo_idx_d = low_idx;
    end
  end

  // Shared registers: flasher, pushbutton history and first-out capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= '0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      ack_q    <= 1'b1;
      rst_q    <= 1'b1;
      fo_idx_q <= '0;
      fo_vld_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
      ack_q    <= ack_pb;
      rst_q    <= rst_pb;
      fo_idx_q <= fo_idx_d;
      fo_vld_q <= fo_vld_d;
    end
  end

  assign first_out_idx = fo_idx_q;
  assign first_out_vld = fo_vld_q;

endmodule
